// File: rtl/guitar_input_port_if.sv
// Processor read port of the guitar input block: one-cycle read strobe in, registered data/valid out.
interface guitar_input_port_if;
  logic        rd_en;
  logic [1:0]  rd_addr;
  logic [31:0] rd_data;
  logic        rd_valid;

  modport master (output rd_en, output rd_addr, input rd_data, input rd_valid);
  modport slave  (input rd_en, input rd_addr, output rd_data, output rd_valid);
endinterface

// File: rtl/guitar_input_port.sv
// Synchronises/debounces two guitar controllers, captures strummed presses as sticky events and hit counts.
// Reads: rd_en registered, data/valid returned on the following edge; no backpressure, one read per strobe cycle.
module guitar_input_port #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 16
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic [5:0]            btn_n,
  input  logic [1:0]            strum,
  guitar_input_port_if.slave    rd,
  output logic [5:0]            note_level,
  output logic                  event_pend
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);
  // Idle pin state: buttons released (high), levers at rest (low).
  localparam logic [7:0] IDLE = 8'b0011_1111;

  logic [7:0]       sync1_q, sync2_q;
  logic [7:0]       stable_q, stable_d;
  logic [DB_W-1:0]  db_cnt_q [8];
  logic [DB_W-1:0]  db_cnt_d [8];
  logic [5:0]       level;
  logic [5:0]       rise;
  logic [5:0]       note_level_q;
  logic [5:0]       evt_q, evt_d, evt_clr;
  logic             event_pend_q;
  logic [CNT_W-1:0] cnt_p1_q, cnt_p1_d, cnt_p2_q, cnt_p2_d;
  logic [CNT_W+1:0] sum_p1, sum_p2;
  logic [1:0]       inc_p1, inc_p2;
  logic             rd_req_q;
  logic [1:0]       rd_addr_q;
  logic [31:0]      rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;

  // Per-channel debounce: a new value must persist DEBOUNCE_CYCLES cycles before acceptance.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < 8; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (db_cnt_q[i] == DB_MAX) begin
          stable_d[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign level = ~stable_q[5:0] & {{3{stable_q[7]}}, {3{stable_q[6]}}};
  // note_level_q is last cycle's level, so it doubles as the edge-detect history.
  assign rise  = level & ~note_level_q;

  always_comb begin
    inc_p1 = 2'(rise[0]) + 2'(rise[1]) + 2'(rise[2]);
    inc_p2 = 2'(rise[3]) + 2'(rise[4]) + 2'(rise[5]);
    sum_p1 = {2'b00, cnt_p1_q} + {{CNT_W{1'b0}}, inc_p1};
    sum_p2 = {2'b00, cnt_p2_q} + {{CNT_W{1'b0}}, inc_p2};
    cnt_p1_d = (sum_p1[CNT_W+1:CNT_W] != 2'b00) ? {CNT_W{1'b1}} : sum_p1[CNT_W-1:0];
    cnt_p2_d = (sum_p2[CNT_W+1:CNT_W] != 2'b00) ? {CNT_W{1'b1}} : sum_p2[CNT_W-1:0];
  end

  always_comb begin
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    evt_clr    = '0;
    if (rd_req_q) begin
      rd_valid_d = 1'b1;
      case (rd_addr_q)
        2'd0: rd_data_d = {26'b0, level};
        2'd1: begin
          rd_data_d = {26'b0, evt_q};
          evt_clr   = evt_q;
        end
        2'd2: rd_data_d = {16'(cnt_p2_q), 16'(cnt_p1_q)};
        default: rd_data_d = {30'b0, event_pend_q, |level};
      endcase
    end
  end

  // New edges are OR'd in after the clear, so an edge coinciding with a read survives it.
  assign evt_d = (evt_q & ~evt_clr) | rise;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync1_q      <= IDLE;
      sync2_q      <= IDLE;
      stable_q     <= IDLE;
      for (int i = 0; i < 8; i++) db_cnt_q[i] <= '0;
      note_level_q <= '0;
      evt_q        <= '0;
      event_pend_q <= 1'b0;
      cnt_p1_q     <= '0;
      cnt_p2_q     <= '0;
      rd_req_q     <= 1'b0;
      rd_addr_q    <= '0;
      rd_data_q    <= '0;
      rd_valid_q   <= 1'b0;
    end else begin
      sync1_q      <= {strum, btn_n};
      sync2_q      <= sync1_q;
      stable_q     <= stable_d;
      for (int i = 0; i < 8; i++) db_cnt_q[i] <= db_cnt_d[i];
      note_level_q <= level;
      evt_q        <= evt_d;
      event_pend_q <= |evt_q;
      cnt_p1_q     <= cnt_p1_d;
      cnt_p2_q     <= cnt_p2_d;
      rd_req_q     <= rd.rd_en;
      rd_addr_q    <= rd.rd_addr;
      rd_data_q    <= rd_data_d;
      rd_valid_q   <= rd_valid_d;
    end
  end

  assign note_level  = note_level_q;
  assign event_pend  = event_pend_q;
  assign rd.rd_data  = rd_data_q;
  assign rd.rd_valid = rd_valid_q;

endmodule
